// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
//   Round-robin arbiter sharing one single-port synchronous memory between
//   NREQ requesters. One command is accepted per cycle and forwarded on a
//   registered memory command port. Read data is routed back to the requester
//   that issued the read through a two-stage tag pipe.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   i_req         per-requester command request
//   i_req_rw      per-requester direction (1=read, 0=write)
//   i_req_add     packed addresses, requester i at [i*AW +: AW]
//   i_req_wdata   packed write data, requester i at [i*DW +: DW]
//   o_gnt         one-hot accept strobe (combinational)
//   o_rvalid      one-hot read-data-valid strobe
//   o_rdata       shared read data, qualified by o_rvalid
//   o_mem_en      memory command valid
//   o_mem_rw      memory direction (1=read, 0=write)
//   o_mem_add     memory address
//   o_mem_din     memory write data
//   i_mem_dout    memory read data, valid one cycle after the read command
//   o_last_gnt    index of the most recently granted requester
module mem_rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = 16,
    parameter int unsigned DW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ-1:0]    i_req_rw,
    input  logic [NREQ*AW-1:0] i_req_add,
    input  logic [NREQ*DW-1:0] i_req_wdata,
    output logic [NREQ-1:0]    o_gnt,
    output logic [NREQ-1:0]    o_rvalid,
    output logic [DW-1:0]      o_rdata,
    output logic               o_mem_en,
    output logic               o_mem_rw,
    output logic [AW-1:0]      o_mem_add,
    output logic [DW-1:0]      o_mem_din,
    input  logic [DW-1:0]      i_mem_dout,
    output logic [2:0]         o_last_gnt
);

    localparam int unsigned IW = 3;

    logic [IW-1:0]   r_last_gnt;
    logic [IW-1:0]   r_ptr;        // first index searched this cycle
    logic            r_mem_en;
    logic            r_mem_rw;
    logic [AW-1:0]   r_mem_add;
    logic [DW-1:0]   r_mem_din;
    logic            r_tag_v;      // tag stage 1: read issued on the memory port
    logic [IW-1:0]   r_tag_id;
    logic [NREQ-1:0] r_rvalid;     // tag stage 2, one-hot
    logic [DW-1:0]   r_rdata_hold;

    logic [NREQ-1:0] w_gnt;
    logic            w_any;
    logic [IW-1:0]   w_idx;
    logic            w_sel_rw;
    logic [AW-1:0]   w_sel_add;
    logic [DW-1:0]   w_sel_din;
    logic            w_rd_live;

    // Round-robin search: indices from r_ptr upward first, then the wrap-around part
    always_comb begin
        w_gnt     = '0;
        w_any     = 1'b0;
        w_idx     = r_last_gnt;
        w_sel_rw  = 1'b1;
        w_sel_add = '0;
        w_sel_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_any && i_req[i] && (IW'(i) >= r_ptr)) begin
                w_any     = 1'b1;
                w_gnt[i]  = 1'b1;
                w_idx     = IW'(i);
                w_sel_rw  = i_req_rw[i];
                w_sel_add = i_req_add[i*AW +: AW];
                w_sel_din = i_req_wdata[i*DW +: DW];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_any && i_req[i] && (IW'(i) < r_ptr)) begin
                w_any     = 1'b1;
                w_gnt[i]  = 1'b1;
                w_idx     = IW'(i);
                w_sel_rw  = i_req_rw[i];
                w_sel_add = i_req_add[i*AW +: AW];
                w_sel_din = i_req_wdata[i*DW +: DW];
            end
        end
        if (rst) begin
            w_gnt = '0;
            w_any = 1'b0;
        end
    end

    // Command register, pointer and read tag pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt   <= '0;
            r_ptr        <= '0;
            r_mem_en     <= 1'b0;
            r_mem_rw     <= 1'b1;
            r_mem_add    <= '0;
            r_mem_din    <= '0;
            r_tag_v      <= 1'b0;
            r_tag_id     <= '0;
            r_rvalid     <= '0;
            r_rdata_hold <= '0;
        end else begin
            r_mem_en <= w_any;
            r_mem_rw <= w_any ? w_sel_rw : 1'b1;
            if (w_any) begin
                r_mem_add  <= w_sel_add;
                r_mem_din  <= w_sel_din;
                r_last_gnt <= w_idx;
                r_ptr      <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
            end
            r_tag_v  <= w_any && w_sel_rw;
            r_tag_id <= w_idx;
            for (int i = 0; i < NREQ; i++) begin
                r_rvalid[i] <= r_tag_v && (r_tag_id == IW'(i));
            end
            if (w_rd_live) begin
                r_rdata_hold <= i_mem_dout;
            end
        end
    end

    // Memory output is live only in the rvalid cycle; hold it afterwards
    assign w_rd_live = |r_rvalid;
    assign o_rdata   = w_rd_live ? i_mem_dout : r_rdata_hold;

    assign o_gnt      = w_gnt;
    assign o_rvalid   = r_rvalid;
    assign o_mem_en   = r_mem_en;
    assign o_mem_rw   = r_mem_rw;
    assign o_mem_add  = r_mem_add;
    assign o_mem_din  = r_mem_din;
    assign o_last_gnt = r_last_gnt;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter
//   Directed bench for mem_rr_arbiter with two requesters and a behavioural
//   single-port synchronous memory. Inputs change and outputs are checked on
//   the falling edge; the DUT and memory update on the rising edge.
module tb_mem_rr_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 16;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_rw;
    logic [NREQ*AW-1:0] req_add;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               mem_en;
    logic               mem_rw;
    logic [AW-1:0]      mem_add;
    logic [DW-1:0]      mem_din;
    logic [DW-1:0]      mem_dout;
    logic [2:0]         last_gnt;

    logic [DW-1:0]      mem [0:(1<<AW)-1];

    int n_chk;
    int n_fail;

    mem_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req),
        .i_req_rw    (req_rw),
        .i_req_add   (req_add),
        .i_req_wdata (req_wdata),
        .o_gnt       (gnt),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .o_mem_en    (mem_en),
        .o_mem_rw    (mem_rw),
        .o_mem_add   (mem_add),
        .o_mem_din   (mem_din),
        .i_mem_dout  (mem_dout),
        .o_last_gnt  (last_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory, registered read port
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_rw) mem_dout <= mem[mem_add];
            else        mem[mem_add] <= mem_din;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive both requesters, then let the combinational grant settle
    task automatic drive(input logic [1:0] r, input logic [1:0] rw,
                         input logic [15:0] a0, input logic [15:0] d0,
                         input logic [15:0] a1, input logic [15:0] d1);
        req       = r;
        req_rw    = rw;
        req_add   = {a1, a0};
        req_wdata = {d1, d0};
        #1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        mem_dout = '0;

        // Reset with both requesting; req0 writes mem[0], req1 writes mem[5]
        drive(2'b11, 2'b00, 16'h0000, 16'h5A00, 16'h0005, 16'h1111);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            step();
            check("rst_gnt",    32'(gnt),    32'h0);
            check("rst_mem_en", 32'(mem_en), 32'h0);
            check("rst_mem_rw", 32'(mem_rw), 32'h1);
            check("rst_rvalid", 32'(rvalid), 32'h0);
        end
        check("rst_mem_add",  32'(mem_add),  32'h0);
        check("rst_last_gnt", 32'(last_gnt), 32'h0);
        rst = 1'b0;
        #1;
        check("first_gnt", 32'(gnt), 32'h1);

        // req1 still waiting; then a lone req1 writes mem[6]
        step();
        drive(2'b10, 2'b00, 16'h0000, 16'h0000, 16'h0005, 16'h1111);
        check("pre_gnt1", 32'(gnt), 32'h2);
        check("pre_last0", 32'(last_gnt), 32'h0);
        step();
        drive(2'b10, 2'b00, 16'h0000, 16'h0000, 16'h0006, 16'h2222);
        check("lone_gnt1", 32'(gnt), 32'h2);
        check("pre_last1", 32'(last_gnt), 32'h1);

        // Write then read requester 0
        step();
        drive(2'b01, 2'b00, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000);
        check("wr_gnt", 32'(gnt), 32'h1);
        step();
        drive(2'b01, 2'b01, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
        check("rd_gnt",     32'(gnt),     32'h1);
        check("wr_mem_en",  32'(mem_en),  32'h1);
        check("wr_mem_rw",  32'(mem_rw),  32'h0);
        check("wr_mem_add", 32'(mem_add), 32'h0010);
        check("wr_mem_din", 32'(mem_din), 32'hBEEF);
        step();
        drive(2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("idle_gnt",   32'(gnt),     32'h0);
        check("rd_mem_en",  32'(mem_en),  32'h1);
        check("rd_mem_rw",  32'(mem_rw),  32'h1);
        check("rd_mem_add", 32'(mem_add), 32'h0010);
        check("rd_early",   32'(rvalid),  32'h0);
        step();
        check("idle_mem_en", 32'(mem_en), 32'h0);
        check("idle_mem_rw", 32'(mem_rw), 32'h1);
        check("idle_add_hold", 32'(mem_add), 32'h0010);
        check("rd_rvalid",   32'(rvalid), 32'h1);
        check("rd_rdata",    32'(rdata),  32'hBEEF);
        step();
        check("rd_rvalid_off", 32'(rvalid), 32'h0);
        check("rdata_hold",    32'(rdata),  32'hBEEF);

        // Move the pointer so that requester 0 is next, then contend
        drive(2'b10, 2'b00, 16'h0000, 16'h0000, 16'h0030, 16'h3333);
        check("align_gnt", 32'(gnt), 32'h2);
        for (int k = 0; k < 6; k++) begin
            step();
            drive(2'b11, 2'b00, 16'h0100, 16'hAAAA, 16'h0200, 16'hBBBB);
            check("rr_gnt", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k > 0)
                check("rr_mem_add", 32'(mem_add), (k % 2 == 0) ? 32'h0200 : 32'h0100);
        end
        step();
        drive(2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("rr_mem_add_last", 32'(mem_add), 32'h0200);
        check("rr_last_gnt", 32'(last_gnt), 32'h1);

        // Concurrent reads routed back to their issuers
        step();
        drive(2'b11, 2'b11, 16'h0005, 16'h0000, 16'h0006, 16'h0000);
        check("route_gnt0", 32'(gnt), 32'h1);
        step();
        drive(2'b10, 2'b11, 16'h0000, 16'h0000, 16'h0006, 16'h0000);
        check("route_gnt1", 32'(gnt), 32'h2);
        step();
        drive(2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("route_rv0", 32'(rvalid), 32'h1);
        check("route_rd0", 32'(rdata),  32'h1111);
        step();
        check("route_rv1", 32'(rvalid), 32'h2);
        check("route_rd1", 32'(rdata),  32'h2222);
        step();
        check("route_rv_off", 32'(rvalid), 32'h0);

        // Reset while a read is in flight
        drive(2'b01, 2'b01, 16'h0005, 16'h0000, 16'h0000, 16'h0000);
        check("flight_gnt", 32'(gnt), 32'h1);
        step();
        rst = 1'b1;
        drive(2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("flight_rvalid", 32'(rvalid), 32'h0);
            step();
        end

        // Address extremes
        drive(2'b01, 2'b00, 16'hFFFF, 16'hA5A5, 16'h0000, 16'h0000);
        check("bnd_wr_gnt", 32'(gnt), 32'h1);
        step();
        drive(2'b01, 2'b01, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        check("bnd_rd_gnt", 32'(gnt), 32'h1);
        step();
        drive(2'b01, 2'b01, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("bnd_rd0_gnt", 32'(gnt), 32'h1);
        check("bnd_mem_add", 32'(mem_add), 32'hFFFF);
        step();
        drive(2'b00, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("bnd_rv_hi", 32'(rvalid), 32'h1);
        check("bnd_rd_hi", 32'(rdata),  32'hA5A5);
        step();
        check("bnd_rv_lo", 32'(rvalid), 32'h1);
        check("bnd_rd_lo", 32'(rdata),  32'h5A00);
        step();
        check("bnd_rv_off", 32'(rvalid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
